handshake_rr_mux: RTL and testbench

Parametrised successor to the single-channel source/drain handshake path. It merges NCH independent valid/ready producer channels into one consumer channel. Arbitration is round-robin or fixed-priority. Accepted beats pass through a DEPTH-entry FIFO and are tagged with the originating channel index. It sits between several source-side producers and a single drain-side consumer.

---
 rtl/handshake_rr_mux_if.sv | 36 +++
 rtl/handshake_rr_mux.sv | 113 +++++++++++
 tb/tb_handshake_rr_mux.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/handshake_rr_mux_if.sv
// handshake_rr_mux_if
// Bundles the producer-side and consumer-side handshake signals of
// handshake_rr_mux.
//   in_valid/in_ready/in_data : NCH producer channels, channel i payload at
//                               in_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready       : single consumer channel handshake
//   out_data/out_chan         : FIFO head payload and originating channel
//   count                     : current FIFO occupancy
// Modports: slave = the mux itself, master = the environment driving it.
interface handshake_rr_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 4
);
  localparam int CHW = $clog2(NCH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CHW-1:0]       out_chan;
  logic [CW-1:0]        count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, count
  );
endinterface

// File: rtl/handshake_rr_mux.sv
// handshake_rr_mux
// Merges NCH valid/ready producer channels into one consumer channel.
// One valid channel is granted per cycle (round-robin when ARB=0, lowest
// index first when ARB=1) while the FIFO has room; accepted beats are
// stored with their channel index in a DEPTH-entry FIFO and presented in
// strict arrival order.
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-low reset
//   bus : handshake_rr_mux_if.slave (in_valid/in_ready/in_data,
//         out_valid/out_ready/out_data/out_chan, count)
module handshake_rr_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int ARB   = 0
) (
  input  logic                clk,
  input  logic                rst,
  handshake_rr_mux_if.slave   bus
);
  localparam int CHW = $clog2(NCH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [CW-1:0]    count_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CHW-1:0]   rr_ptr;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [CHW-1:0]   mem_chan [DEPTH];

  logic             full;
  logic             found;
  logic             push;
  logic             pop;
  logic [NCH-1:0]   grant;
  logic [CHW-1:0]   gidx;
  logic [WIDTH-1:0] gdata;

  // Full is taken from the registered count only, so a same-cycle pop never
  // opens in_ready: there is no out_ready -> in_ready path.
  assign full = (count_q == CW'(DEPTH));

  // Scan channels starting at rr_ptr (or at 0 for fixed priority), wrapping
  // modulo NCH; the first valid channel found wins.
  always_comb begin : arb
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    gidx  = '0;
    grant = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = (ARB == 1) ? k : 32'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        gidx  = CHW'(idx);
      end
    end
    if (found && !full && rst) grant[gidx] = 1'b1;
  end

  assign gdata        = bus.in_data[gidx*WIDTH +: WIDTH];
  assign push         = |grant;
  assign pop          = bus.out_valid & bus.out_ready;
  assign bus.in_ready = grant;

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_data[rd_ptr] : '0;
  assign bus.out_chan  = bus.out_valid ? mem_chan[rd_ptr] : '0;
  assign bus.count     = count_q;

  // Storage is intentionally not reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= gdata;
      mem_chan[wr_ptr] <= gidx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (ARB == 0 && push) begin
        if (gidx == CHW'(NCH - 1)) rr_ptr <= '0;
        else                       rr_ptr <= gidx + CHW'(1);
      end
    end
  end

  a_onehot_ready: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(bus.in_ready));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    full |-> (bus.in_ready == '0));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CW'(DEPTH));
  a_head_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.out_valid && !bus.out_ready) |=>
      ($stable(bus.out_data) && $stable(bus.out_chan)));
endmodule

// File: tb/tb_handshake_rr_mux.sv
// tb_handshake_rr_mux
// Drives a round-robin instance and a fixed-priority instance with the same
// producer/consumer stimulus and compares both against a queue-based model
// every cycle, plus directed checks for the documented scenarios.
module tb_handshake_rr_mux;
  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  handshake_rr_mux_if #(.WIDTH(W), .NCH(N), .DEPTH(D)) b0 ();
  handshake_rr_mux_if #(.WIDTH(W), .NCH(N), .DEPTH(D)) b1 ();

  handshake_rr_mux #(.WIDTH(W), .NCH(N), .DEPTH(D), .ARB(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  handshake_rr_mux #(.WIDTH(W), .NCH(N), .DEPTH(D), .ARB(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    int          ch;
    logic [31:0] d;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   rr0 = 0;
  int   checks = 0;
  int   errors = 0;
  int   g0_last, g1_last;
  logic [3:0]  rdy0, rdy1;
  logic [1:0]  ochan0;
  logic [2:0]  cnt0;
  logic [31:0] odata0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first valid channel in search order.
  function automatic int pick(input int arb, input int ptr, input logic [3:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (arb == 1) ? k : (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; drives inputs, checks outputs, advances the model
  // across the next rising edge, returns at the following negedge.
  task automatic cycle(input logic [3:0] v, input logic [127:0] d, input logic ordy);
    int g0, g1;
    logic [3:0] e0, e1;
    b0.in_valid = v; b1.in_valid = v;
    b0.in_data  = d; b1.in_data  = d;
    b0.out_ready = ordy; b1.out_ready = ordy;
    #1;
    g0 = (rst && q0.size() < D) ? pick(0, rr0, v) : -1;
    g1 = (rst && q1.size() < D) ? pick(1, 0, v) : -1;
    e0 = (g0 >= 0) ? 4'(1 << g0) : 4'b0;
    e1 = (g1 >= 0) ? 4'(1 << g1) : 4'b0;
    g0_last = g0; g1_last = g1;
    rdy0 = b0.in_ready; rdy1 = b1.in_ready;
    ochan0 = b0.out_chan; cnt0 = b0.count; odata0 = b0.out_data;
    chk("rr in_ready",  64'(b0.in_ready),  64'(e0));
    chk("rr out_valid", 64'(b0.out_valid), 64'(q0.size() != 0));
    chk("rr out_data",  64'(b0.out_data),  (q0.size() != 0) ? 64'(q0[0].d) : 64'(0));
    chk("rr out_chan",  64'(b0.out_chan),  (q0.size() != 0) ? 64'(q0[0].ch) : 64'(0));
    chk("rr count",     64'(b0.count),     64'(q0.size()));
    chk("fp in_ready",  64'(b1.in_ready),  64'(e1));
    chk("fp out_valid", 64'(b1.out_valid), 64'(q1.size() != 0));
    chk("fp out_data",  64'(b1.out_data),  (q1.size() != 0) ? 64'(q1[0].d) : 64'(0));
    chk("fp out_chan",  64'(b1.out_chan),  (q1.size() != 0) ? 64'(q1[0].ch) : 64'(0));
    chk("fp count",     64'(b1.count),     64'(q1.size()));
    @(posedge clk);
    if (q0.size() != 0 && ordy) void'(q0.pop_front());
    if (q1.size() != 0 && ordy) void'(q1.pop_front());
    if (g0 >= 0) begin
      q0.push_back('{ch: g0, d: d[g0*32 +: 32]});
      rr0 = (g0 + 1) % N;
    end
    if (g1 >= 0) q1.push_back('{ch: g1, d: d[g1*32 +: 32]});
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    chk("rst rr out_valid", 64'(b0.out_valid), 64'(0));
    chk("rst rr in_ready",  64'(b0.in_ready),  64'(0));
    chk("rst rr count",     64'(b0.count),     64'(0));
    chk("rst rr out_data",  64'(b0.out_data),  64'(0));
    chk("rst rr out_chan",  64'(b0.out_chan),  64'(0));
    chk("rst fp out_valid", 64'(b1.out_valid), 64'(0));
    chk("rst fp in_ready",  64'(b1.in_ready),  64'(0));
    chk("rst fp count",     64'(b1.count),     64'(0));
    q0.delete();
    q1.delete();
    rr0 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    repeat (6) cycle(4'b0, rnd128(), 1'b1);
  endtask

  initial begin
    int acc;
    logic [3:0] v;
    b0.in_valid = '0; b1.in_valid = '0;
    b0.in_data  = '0; b1.in_data  = '0;
    b0.out_ready = 1'b0; b1.out_ready = 1'b0;

    // Power-on reset.
    #1 rst = 1'b0;
    #1;
    chk("por out_valid", 64'(b0.out_valid), 64'(0));
    chk("por in_ready",  64'(b0.in_ready),  64'(0));
    chk("por count",     64'(b0.count),     64'(0));
    chk("por out_data",  64'(b0.out_data),  64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Round-robin saturation: grants rotate, out_chan lags by one cycle.
    for (int k = 0; k < 8; k++) begin
      cycle(4'hF, rnd128(), 1'b1);
      chk("sat grant", 64'(rdy0), 64'(1 << (k % 4)));
      chk("sat count", 64'(cnt0), (k == 0) ? 64'(0) : 64'(1));
      if (k >= 1) chk("sat out_chan", 64'(ochan0), 64'((k - 1) % 4));
    end
    drain();

    // Full/backpressure on channel 1 with payloads 0xA0..0xA4.
    acc = 0;
    for (int s = 0; s < 10; s++) begin
      v = (acc < 5) ? 4'b0010 : 4'b0000;
      cycle(v, {64'h0, 32'(32'hA0 + acc), 32'h0}, (s >= 5));
      if (s == 4) begin
        chk("full count", 64'(cnt0), 64'(4));
        chk("full in_ready", 64'(rdy0), 64'(0));
      end
      if (s == 5) begin
        chk("full pop in_ready", 64'(rdy0), 64'(0));
        chk("full head", 64'(odata0), 64'(32'hA0));
      end
      if (s == 6) chk("refill in_ready", 64'(rdy0), 64'(4'b0010));
      if (g0_last == 1) acc++;
    end
    chk("full accepted beats", 64'(acc), 64'(5));
    drain();

    // Pointer skip: ch2 alone three times, then ch0+ch2 alternate from ch0.
    repeat (3) cycle(4'b0100, rnd128(), 1'b1);
    cycle(4'b0101, rnd128(), 1'b1); chk("skip grant a", 64'(rdy0), 64'(4'b0001));
    cycle(4'b0101, rnd128(), 1'b1); chk("skip grant b", 64'(rdy0), 64'(4'b0100));
    cycle(4'b0101, rnd128(), 1'b1); chk("skip grant c", 64'(rdy0), 64'(4'b0001));
    drain();

    // Fixed priority: ch0 always beats ch3 until ch0 drops.
    repeat (6) begin
      cycle(4'b1001, rnd128(), 1'b1);
      chk("fp grant ch0", 64'(rdy1), 64'(4'b0001));
    end
    cycle(4'b1000, rnd128(), 1'b1);
    chk("fp grant ch3", 64'(rdy1), 64'(4'b1000));
    drain();

    // Hold occupancy at 2 with simultaneous push and pop; pointers wrap.
    repeat (2) cycle(4'b0001, rnd128(), 1'b0);
    for (int k = 0; k < 9; k++) begin
      cycle(4'b0001, rnd128(), 1'b1);
      chk("wrap count", 64'(cnt0), 64'(2));
    end
    drain();

    // Reset in the middle of traffic.
    repeat (3) cycle(4'b0010, rnd128(), 1'b0);
    chk("pre-reset count", 64'(b0.count), 64'(3));
    chk("pre-reset out_valid", 64'(b0.out_valid), 64'(1));
    reset_pulse();
    cycle(4'hF, rnd128(), 1'b1);
    chk("post-reset grant", 64'(rdy0), 64'(4'b0001));
    drain();

    // Randomized traffic with varying consumer throttle and rare resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse();
      cycle(4'($urandom), rnd128(), ($urandom_range(0, 3) < ((i / 50) % 4)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
